// File: rtl/dsp_path_switch_if.sv
// Stream bundle for dsp_path_switch: NUM_PATHS valid/ready sources in, one
// valid/ready sink out.
interface dsp_path_switch_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_PATHS  = 4
);
  logic [NUM_PATHS-1:0][DATA_WIDTH-1:0] src_data_in;
  logic [NUM_PATHS-1:0]                 src_valid_in;
  logic [NUM_PATHS-1:0]                 src_ready_out;
  logic [DATA_WIDTH-1:0]                dst_data_out;
  logic                                 dst_valid_out;
  logic                                 dst_ready_in;

  modport slave (
    input  src_data_in, src_valid_in, dst_ready_in,
    output src_ready_out, dst_data_out, dst_valid_out
  );

  modport master (
    output src_data_in, src_valid_in, dst_ready_in,
    input  src_ready_out, dst_data_out, dst_valid_out
  );
endinterface

// File: rtl/dsp_path_switch.sv
// N-way stream selector with hitless switching: stops accepting, drains the
// output FIFO, then moves to the newly requested path.
module dsp_path_switch #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_PATHS  = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [1:0]            addr,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  dsp_path_switch_if.slave      strm,
  output logic                  switching_out
);

  localparam int unsigned SEL_W = $clog2(NUM_PATHS);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LW    = AW + 1;
  localparam logic [DATA_WIDTH-2:0] SEL_LIMIT = (DATA_WIDTH-1)'(NUM_PATHS);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_RUN      = 2'd1,
    ST_DRAIN    = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [SEL_W-1:0]      active_sel_q, active_sel_d;
  logic                  pend_en_q, pend_en_d;
  logic [SEL_W-1:0]      pend_sel_q, pend_sel_d;
  logic                  switching_q;
  logic [DATA_WIDTH-1:0] count_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]         level_q;

  logic                  ctrl_wr_c;
  logic                  wr_en_c;
  logic [SEL_W-1:0]      wr_sel_c;
  logic                  full_c, empty_c, push_c, pop_c;
  logic [NUM_PATHS-1:0]  ready_c;
  logic [15:0]           status_c;

  // Out-of-range selects are rejected as a whole, including the enable bit.
  assign wr_en_c   = wdata[0];
  assign wr_sel_c  = wdata[SEL_W:1];
  assign ctrl_wr_c = write_en && (addr == 2'd0) && (wdata[DATA_WIDTH-1:1] < SEL_LIMIT);

  assign full_c  = (level_q == LW'(FIFO_DEPTH));
  assign empty_c = (level_q == '0);

  always_comb begin
    ready_c = '0;
    if (state_q == ST_RUN && !full_c) ready_c[active_sel_q] = 1'b1;
  end

  assign push_c = |(strm.src_valid_in & ready_c);
  assign pop_c  = !empty_c && strm.dst_ready_in;

  // Next-state: pending CTRL always tracks the latest accepted write.
  always_comb begin
    state_d      = state_q;
    active_sel_d = active_sel_q;
    pend_en_d    = pend_en_q;
    pend_sel_d   = pend_sel_q;
    if (ctrl_wr_c) begin
      pend_en_d  = wr_en_c;
      pend_sel_d = wr_sel_c;
    end
    case (state_q)
      ST_DISABLED: begin
        if (ctrl_wr_c && wr_en_c) begin
          active_sel_d = wr_sel_c;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        if (ctrl_wr_c && (!wr_en_c || wr_sel_c != active_sel_q)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (empty_c) begin
          active_sel_d = pend_sel_d;
          state_d      = pend_en_d ? ST_RUN : ST_DISABLED;
        end
      end
      default: state_d = ST_DISABLED;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= ST_DISABLED;
      active_sel_q <= '0;
      pend_en_q    <= 1'b0;
      pend_sel_q   <= '0;
      switching_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_sel_q <= active_sel_d;
      pend_en_q    <= pend_en_d;
      pend_sel_q   <= pend_sel_d;
      switching_q  <= (state_d == ST_DRAIN);
    end
  end

  // In-order output FIFO; ready is taken from full only, so no push-through-pop.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_c) begin
        mem_q[wr_ptr_q] <= strm.src_data_in[active_sel_q];
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(push_c) - LW'(pop_c);
    end
  end

  // Output handshake counter; a register write clears it and beats a same-cycle increment.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count_q <= '0;
    end else if (write_en && addr == 2'd2) begin
      count_q <= '0;
    end else if (pop_c) begin
      count_q <= count_q + DATA_WIDTH'(1);
    end
  end

  assign status_c = {8'(level_q), 4'(active_sel_q), 2'b00, state_q};

  always_comb begin
    rdata = '0;
    case (addr)
      2'd0:    rdata = DATA_WIDTH'({pend_sel_q, pend_en_q});
      2'd1:    rdata = DATA_WIDTH'(status_c);
      2'd2:    rdata = count_q;
      default: rdata = '0;
    endcase
  end

  assign strm.src_ready_out = ready_c;
  assign strm.dst_data_out  = mem_q[rd_ptr_q];
  assign strm.dst_valid_out = !empty_c;
  assign switching_out      = switching_q;

endmodule
